seven_segment_mux: RTL and testbench
====================================

# seven_segment_mux

AHB-Lite slave driving a multiplexed common-anode seven-segment display of NUM_DIGITS digits, parametrised in digit count and scan rate. Adds full hex decode (0-F), per-digit decimal points, per-digit blinking from an internal timer, leading-zero blanking, display enable and register readback. Sits on the AHB bus beside the other cycle-computer peripherals; pads connect directly to segment and digit outputs.

## Interface
- NUM_DIGITS, 4: digits driven, legal range 1..8.
- SCAN_DIV, 1024: HCLK cycles each digit is active, at least 2.
- BLINK_DIV, 64: complete scans per blink half-period, at least 1.

- HCLK  in  1  clock.
- HRESETn  in  1  reset HRESETn, asynchronous, active-low; clock HCLK.
- HSEL, HREADY, HWRITE  in  1 each  AHB-Lite controls.
- HTRANS  in  2  transfer type; IDLE (2'b00) ignored.
- HSIZE  in  3  ignored; all accesses are treated as word accesses.
- HADDR  in  32  only HADDR[4:2] decoded.
- HWDATA  in  32  write data.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  tied 1, zero wait states.
- SegA..SegG, DP  out  1 each  segment drive, active-high, registered.
- nDigit  out  NUM_DIGITS  digit select, active-low one-hot, registered.

## Operation
- Register map (offset from HADDR[4:2]):
  - 0x00 DIGITS, bits [4*NUM_DIGITS-1:0]: nibble i = hex value of digit i; digit 0 is least significant and rightmost.
  - 0x04 DPMASK, bits [NUM_DIGITS-1:0]: decimal point on for digit i.
  - 0x08 BLINK, bits [NUM_DIGITS-1:0]: digit i blinks.
  - 0x0C CTRL: bit0 EN, bit1 LZB.
  - 0x10 STATUS, read-only: [2:0] current digit index; bit 8 blink phase.
- Reset values: DIGITS 0, DPMASK 0, BLINK 0, CTRL 0x1 (enabled, LZB off).
- AHB address phase:
  - Accepted when HSEL && HREADY && HTRANS != IDLE.
  - Address and HWRITE registered; write performed at the end of the data phase.
- AHB data phase:
  - Reads return the selected register zero-extended, combinationally from the registered address.
  - Unmapped offsets (0x14-0x1C) and STATUS writes: writes ignored, reads return 0.
  - Bits above the valid widths are ignored on write and read as 0.
- Scan:
  - Digit index advances by 1 every SCAN_DIV cycles and wraps NUM_DIGITS-1 -> 0.
  - Blink phase toggles after BLINK_DIV index wraps; phase 0 = visible.
- Digit i is blanked when any of these holds:
  - EN=0.
  - BLINK[i]=1 and the blink phase is 1.
  - LZB=1, i>0, and every digit j>=i has value 0 with DPMASK[j]=0.
- A blanked digit drives nDigit all ones, all segments 0 and DP 0. Otherwise nDigit has only bit i low, segments show the hex glyph and DP = DPMASK[i].
- Glyphs use the standard hex font (A-F as A, b, C, d, E, F); 0 = A-F on, G off.
- EN=0:
  - Scan and blink counters held at 0.
  - Re-enable restarts at digit 0 with blink phase 0.

## Timing
- Outputs after reset: nDigit all ones, all segments 0, DP 0.
- First HCLK edge after reset release: digit 0 shown (glyph 0, nDigit = ~1).
- Outputs are registered, so they reflect the index and registers from the previous cycle.
- Write latency: register updated at the data-phase edge; display changes 1 cycle later if that digit is active.
- Back-to-back write then read of the same register returns the new value.
- Write of EN=0 on the same cycle as a scan terminal count: disable wins and the counters clear.
- Blink-phase toggle coincident with a BLINK write: the new mask applies with the new phase.
- Asynchronous reset mid-scan or mid-transfer: all registers, counters and outputs return to reset values immediately. The pending transfer is dropped.

## Structure
- Package seven_segment_pkg holds:
  - Register offset constants.
  - CTRL bit positions.
  - A 16-entry hex-to-segment constant and a function seg7_glyph(logic [3:0]) returning {A..G}.
- Sub-module seg_scan_timer(SCAN_DIV, BLINK_DIV, NUM_DIGITS): scan prescaler, digit index and blink phase, with an enable input that also clears.
- The top level holds the AHB register file, blanking logic and output registers.

## Test plan
- Reset release, default parameters: outputs blank during reset; 1 cycle later nDigit=4'b1110 with glyph 0. Read CTRL returns 0x1.
- NUM_DIGITS=4, SCAN_DIV=4: write DIGITS=0x0000_ABCD, DPMASK=0x2. The scan sequence over 16 cycles is d, C (DP on), b, A on nDigit 1110, 1101, 1011, 0111, each held 4 cycles.
- Write DIGITS=0x0000_0042, CTRL=0x3 (LZB): digits 3 and 2 blanked. Then set DPMASK=0x4: digit 2 shows 0 with DP and digit 3 stays blank.
- BLINK_DIV=2, BLINK=0x1: digit 0 visible for 2 scans, blank for 2 scans, repeating. STATUS bit 8 tracks the blink phase.
- Write CTRL=0x0 mid-scan: next cycle all outputs blank and STATUS reads 0. Write CTRL=0x1: digit 0 shown 1 cycle later.
- Read offset 0x18 returns 0; write 0x14 has no effect. Assert HRESETn low mid-write: the register keeps its reset value.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment display controller: register
// offsets (word index taken from HADDR[4:2]), CTRL bit positions and the
// hex font used to turn a nibble into segment drive.
package seven_segment_pkg;

    // Register word offsets (HADDR[4:2])
    localparam logic [2:0] OFF_DIGITS = 3'd0;
    localparam logic [2:0] OFF_DPMASK = 3'd1;
    localparam logic [2:0] OFF_BLINK  = 3'd2;
    localparam logic [2:0] OFF_CTRL   = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;

    // CTRL bit positions
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_LZB_BIT = 1;

    // STATUS field positions
    localparam int STATUS_PHASE_BIT = 8;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    // Hex font, {A,B,C,D,E,F,G} with A in the MSB; A-F drawn as A b C d E F
    localparam logic [6:0] SEG7_FONT [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79,
        7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F,
        7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    function automatic logic [6:0] seg7_glyph(input logic [3:0] value);
        return SEG7_FONT[value];
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Scan prescaler, digit index and blink phase for the multiplexed display.
// en_i low holds every counter at zero, so re-enabling restarts the scan at
// digit 0 with the blink phase visible.
module seg_scan_timer #(
    parameter int SCAN_DIV   = 1024,
    parameter int BLINK_DIV  = 64,
    parameter int NUM_DIGITS = 4,
    parameter int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             en_i,
    output logic [IDX_W-1:0] digit_idx_o,
    output logic             blink_phase_o
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int WRAP_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [WRAP_W-1:0] WRAP_LAST = WRAP_W'(BLINK_DIV - 1);

    logic [SCAN_W-1:0] scan_q,  scan_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;
    logic              phase_q, phase_d;

    // Next-state: prescale, advance digit on terminal count, toggle phase after BLINK_DIV wraps
    always_comb begin
        scan_d  = scan_q;
        idx_d   = idx_q;
        wraps_d = wraps_q;
        phase_d = phase_q;
        if (!en_i) begin
            scan_d  = '0;
            idx_d   = '0;
            wraps_d = '0;
            phase_d = 1'b0;
        end else if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
                if (wraps_q == WRAP_LAST) begin
                    wraps_d = '0;
                    phase_d = ~phase_q;
                end else begin
                    wraps_d = wraps_q + WRAP_W'(1);
                end
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            scan_d = scan_q + SCAN_W'(1);
        end
    end

    // Counter state registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            scan_q  <= '0;
            idx_q   <= '0;
            wraps_q <= '0;
            phase_q <= 1'b0;
        end else begin
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            wraps_q <= wraps_d;
            phase_q <= phase_d;
        end
    end

    assign digit_idx_o   = idx_q;
    assign blink_phase_o = phase_q;

endmodule

// File: rtl/seven_segment_mux.sv
// AHB-Lite slave driving a multiplexed common-anode seven-segment display.
// Holds the register file, blanking logic and registered pad outputs; the
// scan/blink timing lives in seg_scan_timer.
module seven_segment_mux
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1024,
    parameter int BLINK_DIV  = 64
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic                  HREADY,
    input  logic                  HWRITE,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HADDR,
    input  logic [31:0]           HWDATA,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  SegA,
    output logic                  SegB,
    output logic                  SegC,
    output logic                  SegD,
    output logic                  SegE,
    output logic                  SegF,
    output logic                  SegG,
    output logic                  DP,
    output logic [NUM_DIGITS-1:0] nDigit
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIG_W = 4 * NUM_DIGITS;

    // Bus phase state
    logic       dphase_wr_q;
    logic [2:0] addr_q;
    logic       accept_s;

    // Register file
    logic [DIG_W-1:0]      digits_q, digits_d;
    logic [NUM_DIGITS-1:0] dpmask_q, dpmask_d;
    logic [NUM_DIGITS-1:0] blink_q,  blink_d;
    logic                  ctrl_en_q, ctrl_en_d;
    logic                  ctrl_lzb_q, ctrl_lzb_d;

    // Timer
    logic [IDX_W-1:0] digit_idx_s;
    logic             blink_phase_s;
    logic             timer_en_s;

    // Display path
    logic [31:0]           digits_ext_s;
    logic [7:0]            dp_ext_s;
    logic [7:0]            blink_ext_s;
    logic [7:0]            lzb_blank_s;
    logic                  zero_run_s;
    logic [2:0]            idx3_s;
    logic [3:0]            nibble_s;
    logic                  blank_s;
    logic [6:0]            seg_d, seg_q;
    logic                  dp_d, dp_q;
    logic [NUM_DIGITS-1:0] ndigit_d, ndigit_q;

    // Inputs that carry no information for this slave
    logic unused_s;
    assign unused_s = ^{HSIZE, HADDR[31:5], HADDR[1:0], HWDATA};

    assign accept_s  = HSEL && HREADY && (HTRANS != HTRANS_IDLE);
    assign HREADYOUT = 1'b1;

    // Address phase capture; a data-phase write is pending for one cycle
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dphase_wr_q <= 1'b0;
            addr_q      <= 3'd0;
        end else if (HREADY) begin
            dphase_wr_q <= accept_s && HWRITE;
            addr_q      <= accept_s ? HADDR[4:2] : addr_q;
        end else begin
            dphase_wr_q <= dphase_wr_q;
            addr_q      <= addr_q;
        end
    end

    // Register write decode at the end of the data phase; STATUS and holes ignore writes
    always_comb begin
        digits_d   = digits_q;
        dpmask_d   = dpmask_q;
        blink_d    = blink_q;
        ctrl_en_d  = ctrl_en_q;
        ctrl_lzb_d = ctrl_lzb_q;
        if (dphase_wr_q) begin
            case (addr_q)
                OFF_DIGITS: digits_d = HWDATA[DIG_W-1:0];
                OFF_DPMASK: dpmask_d = HWDATA[NUM_DIGITS-1:0];
                OFF_BLINK:  blink_d  = HWDATA[NUM_DIGITS-1:0];
                OFF_CTRL: begin
                    ctrl_en_d  = HWDATA[CTRL_EN_BIT];
                    ctrl_lzb_d = HWDATA[CTRL_LZB_BIT];
                end
                default: begin
                    digits_d = digits_q;
                end
            endcase
        end else begin
            digits_d = digits_q;
        end
    end

    // Register file state
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            digits_q   <= '0;
            dpmask_q   <= '0;
            blink_q    <= '0;
            ctrl_en_q  <= 1'b1;
            ctrl_lzb_q <= 1'b0;
        end else begin
            digits_q   <= digits_d;
            dpmask_q   <= dpmask_d;
            blink_q    <= blink_d;
            ctrl_en_q  <= ctrl_en_d;
            ctrl_lzb_q <= ctrl_lzb_d;
        end
    end

    // Timer runs only when EN is set both now and after this cycle's write,
    // so a disable landing on a terminal count still clears the counters.
    assign timer_en_s = ctrl_en_q && ctrl_en_d;

    seg_scan_timer #(
        .SCAN_DIV   (SCAN_DIV),
        .BLINK_DIV  (BLINK_DIV),
        .NUM_DIGITS (NUM_DIGITS),
        .IDX_W      (IDX_W)
    ) u_timer (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .en_i          (timer_en_s),
        .digit_idx_o   (digit_idx_s),
        .blink_phase_o (blink_phase_s)
    );

    // Read mux from the registered address; unmapped offsets read as zero
    always_comb begin
        HRDATA = 32'h0000_0000;
        case (addr_q)
            OFF_DIGITS: HRDATA = 32'(digits_q);
            OFF_DPMASK: HRDATA = 32'(dpmask_q);
            OFF_BLINK:  HRDATA = 32'(blink_q);
            OFF_CTRL: begin
                HRDATA[CTRL_EN_BIT]  = ctrl_en_q;
                HRDATA[CTRL_LZB_BIT] = ctrl_lzb_q;
            end
            OFF_STATUS: begin
                HRDATA[2:0]              = 3'(digit_idx_s);
                HRDATA[STATUS_PHASE_BIT] = blink_phase_s;
            end
            default: HRDATA = 32'h0000_0000;
        endcase
    end

    // Blanking decision and glyph selection for the active digit
    always_comb begin
        digits_ext_s = 32'(digits_q);
        dp_ext_s     = 8'(dpmask_q);
        blink_ext_s  = 8'(blink_q);
        idx3_s       = 3'(digit_idx_s);
        nibble_s     = digits_ext_s[{idx3_s, 2'b00} +: 4];
        lzb_blank_s  = 8'h00;
        zero_run_s   = 1'b1;
        // Walk from the most significant digit down: a digit is a leading
        // zero while it and everything above it is 0 with no decimal point.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run_s     = zero_run_s && (digits_q[4*i +: 4] == 4'h0) && !dpmask_q[i];
            lzb_blank_s[i] = zero_run_s && (i != 0);
        end
        blank_s = !ctrl_en_q
               || (blink_ext_s[idx3_s] && blink_phase_s)
               || (ctrl_lzb_q && lzb_blank_s[idx3_s]);
        if (blank_s) begin
            ndigit_d = '1;
            seg_d    = 7'h00;
            dp_d     = 1'b0;
        end else begin
            ndigit_d = ~(NUM_DIGITS'(1'b1) << digit_idx_s);
            seg_d    = seg7_glyph(nibble_s);
            dp_d     = dp_ext_s[idx3_s];
        end
    end

    // Registered pad drive
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ndigit_q <= '1;
            seg_q    <= 7'h00;
            dp_q     <= 1'b0;
        end else begin
            ndigit_q <= ndigit_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign {SegA, SegB, SegC, SegD, SegE, SegF, SegG} = seg_q;
    assign DP     = dp_q;
    assign nDigit = ndigit_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Self-checking bench for seven_segment_mux with a fast scan (SCAN_DIV=4,
// BLINK_DIV=2). A cycle model expressed as elapsed enabled cycles predicts
// each registered output; expectations go to a scoreboard queue when the
// stimulus is applied and are popped when the DUT output is sampled.
module tb_seven_segment_mux;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BD = 2;

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL    = 1'b0;
    logic        HREADY  = 1'b1;
    logic        HWRITE  = 1'b0;
    logic [1:0]  HTRANS  = 2'b00;
    logic [2:0]  HSIZE   = 3'b010;
    logic [31:0] HADDR   = 32'h0;
    logic [31:0] HWDATA  = 32'h0;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        SegA, SegB, SegC, SegD, SegE, SegF, SegG, DP;
    logic [ND-1:0] nDigit;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    // Reference model state
    logic [15:0] m_dig;
    logic [3:0]  m_dp, m_bl;
    logic [1:0]  m_ctrl;
    int          m_t;
    logic        m_wpend;
    logic [2:0]  m_waddr;

    seven_segment_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
        .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HADDR(HADDR),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
        .SegA(SegA), .SegB(SegB), .SegC(SegC), .SegD(SegD), .SegE(SegE),
        .SegF(SegF), .SegG(SegG), .DP(DP), .nDigit(nDigit)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dut_out();
        return {20'h0, nDigit, SegA, SegB, SegC, SegD, SegE, SegF, SegG, DP};
    endfunction

    function automatic logic [6:0] font(input logic [3:0] v);
        case (v)
            4'h0: font = 7'b1111110;  4'h1: font = 7'b0110000;
            4'h2: font = 7'b1101101;  4'h3: font = 7'b1111001;
            4'h4: font = 7'b0110011;  4'h5: font = 7'b1011011;
            4'h6: font = 7'b1011111;  4'h7: font = 7'b1110000;
            4'h8: font = 7'b1111111;  4'h9: font = 7'b1111011;
            4'hA: font = 7'b1110111;  4'hB: font = 7'b0011111;
            4'hC: font = 7'b1001110;  4'hD: font = 7'b0111101;
            4'hE: font = 7'b1001111;  default: font = 7'b1000111;
        endcase
    endfunction

    function automatic int m_idx();
        return (m_t / SD) % ND;
    endfunction

    function automatic int m_phase();
        return ((m_t / (SD * ND)) / BD) % 2;
    endfunction

    function automatic logic [31:0] exp_out();
        int   idx;
        logic blank;
        logic z;
        idx   = m_idx();
        blank = !m_ctrl[0] || (m_bl[idx] && m_phase() == 1);
        z     = 1'b1;
        for (int j = idx; j < ND; j++) begin
            if (m_dig[j*4 +: 4] != 4'h0 || m_dp[j]) z = 1'b0;
        end
        if (m_ctrl[1] && idx > 0 && z) blank = 1'b1;
        if (blank) return 32'h0000_0F00;
        return {20'h0, ~(4'b0001 << idx), font(m_dig[idx*4 +: 4]), m_dp[idx]};
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        logic [31:0] r;
        logic [31:0] ix;
        logic [31:0] ph;
        ix = m_idx();
        ph = m_phase();
        case (a)
            3'd0: r = {16'h0, m_dig};
            3'd1: r = {28'h0, m_dp};
            3'd2: r = {28'h0, m_bl};
            3'd3: r = {30'h0, m_ctrl};
            3'd4: r = {23'h0, ph[0], 5'h0, ix[2:0]};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_dig = 16'h0; m_dp = 4'h0; m_bl = 4'h0; m_ctrl = 2'b01;
        m_t = 0; m_wpend = 1'b0; m_waddr = 3'd0;
    endtask

    // One clock: predict the output for the coming edge, advance the model, compare
    task automatic cycle();
        exp_t        e;
        logic [15:0] nd;
        logic [3:0]  ndp, nbl;
        logic [1:0]  nc;
        e.tag = "out";
        e.val = exp_out();
        sb_q.push_back(e);
        nd = m_dig; ndp = m_dp; nbl = m_bl; nc = m_ctrl;
        if (m_wpend) begin
            case (m_waddr)
                3'd0: nd  = HWDATA[15:0];
                3'd1: ndp = HWDATA[3:0];
                3'd2: nbl = HWDATA[3:0];
                3'd3: nc  = HWDATA[1:0];
                default: nd = m_dig;
            endcase
        end
        @(posedge HCLK);
        m_t     = (m_ctrl[0] && nc[0]) ? m_t + 1 : 0;
        m_dig   = nd; m_dp = ndp; m_bl = nbl; m_ctrl = nc;
        m_wpend = HSEL && (HTRANS != 2'b00) && HWRITE;
        if (HSEL && HTRANS != 2'b00) m_waddr = HADDR[4:2];
        #1;
        e = sb_q.pop_front();
        chk(e.tag, dut_out(), e.val);
    endtask

    task automatic idle_bus();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        cycle();
        idle_bus(); HWDATA = d;
        cycle();
    endtask

    // Read; when use_model is 0 the caller supplies the expected constant
    task automatic rd(input logic [31:0] a, input string tag, input bit use_model, input logic [31:0] cval);
        exp_t e;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        cycle();
        idle_bus();
        e.tag = tag;
        e.val = use_model ? model_read(a[4:2]) : cval;
        sb_q.push_back(e);
        e = sb_q.pop_front();
        chk(e.tag, HRDATA, e.val);
    endtask

    initial begin
        int cnt;
        model_reset();
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_out", dut_out(), 32'h0000_0F00);
        chk("rst_hready", {31'h0, HREADYOUT}, 32'h1);
        @(negedge HCLK);
        HRESETn = 1'b1;
        cycle();
        chk("first_digit", dut_out(), 32'h0000_0EFC);
        rd(32'h0C, "ctrl_rst", 1'b0, 32'h1);

        // Hex glyphs with a decimal point on digit 1
        wr(32'h00, 32'h0000_ABCD);
        wr(32'h04, 32'h0000_0002);
        run(20);
        rd(32'h00, "digits_rb", 1'b0, 32'h0000_ABCD);

        // Leading-zero blanking
        wr(32'h00, 32'h0000_0042);
        wr(32'h0C, 32'h0000_0003);
        wr(32'h04, 32'h0000_0000);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            cycle();
            if (nDigit[3] == 1'b0 || nDigit[2] == 1'b0) cnt++;
        end
        chk("lzb_hidden", cnt, 32'd0);
        wr(32'h04, 32'h0000_0004);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            cycle();
            if (dut_out() == 32'h0000_0BFD) cnt++;
            if (nDigit[3] == 1'b0) cnt = cnt + 100;
        end
        chk("lzb_dp_digit2", cnt, 32'd4);

        // Blinking on digit 0 with STATUS tracking the phase
        wr(32'h0C, 32'h0000_0001);
        wr(32'h04, 32'h0000_0000);
        wr(32'h08, 32'h0000_0001);
        for (int k = 0; k < 12; k++) begin
            rd(32'h10, "status_blink", 1'b1, 32'h0);
            run(7);
        end

        // Disable landing on a scan terminal count
        for (int k = 0; k < SD && (m_t % SD) != 2; k++) cycle();
        wr(32'h0C, 32'h0000_0000);
        cycle();
        chk("dis_blank", dut_out(), 32'h0000_0F00);
        rd(32'h10, "status_dis", 1'b0, 32'h0);
        run(5);
        wr(32'h0C, 32'h0000_0001);
        cycle();
        chk("reen_digit0", dut_out(), 32'h0000_0EDA);
        run(6);

        // Holes, read-only STATUS, masking of unused bits, back-to-back write/read
        rd(32'h18, "hole_rd", 1'b0, 32'h0);
        wr(32'h14, 32'hFFFF_FFFF);
        wr(32'h10, 32'hFFFF_FFFF);
        rd(32'h00, "after_hole_wr", 1'b0, 32'h0000_0042);
        wr(32'h04, 32'hFFFF_FFF0);
        rd(32'h04, "dp_mask_bits", 1'b0, 32'h0);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h08;
        cycle();
        HWRITE = 1'b0; HWDATA = 32'hFFFF_FFFA;
        cycle();
        idle_bus();
        chk("b2b_rd", HRDATA, 32'h0000_000A);
        wr(32'h08, 32'h0000_0000);
        run(8);

        // Asynchronous reset in the middle of a write data phase
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h00;
        cycle();
        idle_bus(); HWDATA = 32'h0000_1234;
        #2;
        HRESETn = 1'b0;
        #1;
        chk("async_rst_out", dut_out(), 32'h0000_0F00);
        @(posedge HCLK);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        model_reset();
        cycle();
        rd(32'h00, "digits_after_rst", 1'b0, 32'h0);
        rd(32'h0C, "ctrl_after_rst", 1'b0, 32'h1);
        run(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
